lap_frame_arbiter: RTL

- Frame-granular scheduler that shares one `laplacian` filter instance between two pixel sources.
- Each grant covers a whole 16x16 frame: pulse the filter reset, stream 256 input pixels, then drain until 256 filtered pixels have come out.
- The filtered stream is tagged with its owner and returned to the system side.
- Sits between the two source streams and the `laplacian` instance.

---
 rtl/lap_frame_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/lap_frame_arbiter.sv
// lap_frame_arbiter: frame-granular round-robin scheduler sharing one laplacian
// filter between two pixel sources. Each grant covers a whole frame: clear the
// filter, feed FRAME_PIX pixels, then drain until FRAME_PIX results are out.
// Optional feature: define LAP_DRAIN_TIMEOUT_EN to abort a DRAIN that sees no
// filter output for DRAIN_TIMEOUT cycles (err pulse instead of frame_done).
module lap_frame_arbiter #(
    parameter int PIX_W         = 8,
    parameter int FRAME_PIX     = 256,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [1:0]       s_valid,
    input  logic [PIX_W-1:0] s_pixel0,
    input  logic [PIX_W-1:0] s_pixel1,
    output logic [1:0]       s_ready,
    output logic             f_rst,
    output logic             f_valid_in,
    output logic [PIX_W-1:0] f_pixel_in,
    input  logic             f_valid_out,
    input  logic [PIX_W-1:0] f_pixel_out,
    output logic             m_valid,
    output logic [PIX_W-1:0] m_pixel,
    output logic             m_owner,
    output logic             frame_done,
    output logic             busy,
    output logic             err
);

    localparam int CW = $clog2(FRAME_PIX) + 1;
    localparam logic [CW-1:0] FRAME_FULL = CW'(FRAME_PIX);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_PIX - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   in_cnt, out_cnt;
    logic            owner, last_owner, grant_owner;
    logic            feed_open, xfer, out_fire, timeout;

    // Grant: a lone requester wins; on a tie the source that did not go last wins.
    assign grant_owner = (s_valid == 2'b11) ? ~last_owner : s_valid[1];

    assign feed_open  = (state == FEED) && (in_cnt < FRAME_FULL);
    assign xfer       = feed_open && s_valid[owner];
    assign s_ready    = feed_open ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign f_valid_in = xfer;
    assign f_pixel_in = owner ? s_pixel1 : s_pixel0;
    assign f_rst      = rst || (state == CLEAR);
    assign busy       = (state != IDLE);
    assign m_owner    = owner;
    assign out_fire   = ((state == FEED) || (state == DRAIN)) && f_valid_out
                        && (out_cnt < FRAME_FULL);

`ifdef LAP_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(DRAIN_TIMEOUT) + 1;
    logic [TW-1:0] drain_cnt;

    // Idle-cycle counter for DRAIN; any filter output restarts the count.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (state == CLEAR) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= f_valid_out ? '0 : drain_cnt + TW'(1);
        end
    end

    // The current idle cycle is the DRAIN_TIMEOUT-th one in a row.
    assign timeout = (state == DRAIN) && (out_cnt != FRAME_FULL) && !f_valid_out
                     && (drain_cnt == TW'(DRAIN_TIMEOUT - 1));
    assign err     = timeout;
`else
    // No watchdog: DRAIN waits on the filter indefinitely.
    assign timeout = 1'b0;
    assign err     = timeout & (DRAIN_TIMEOUT != 0);
`endif

    // State register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic and the frame_done pulse.
    always_comb begin
        state_nx   = state;
        frame_done = 1'b0;
        case (state)
            IDLE:  if (|s_valid) state_nx = CLEAR;
            CLEAR: state_nx = FEED;
            FEED:  if (xfer && (in_cnt == FRAME_LAST)) state_nx = DRAIN;
            DRAIN: begin
                if (out_cnt == FRAME_FULL) state_nx = DONE;
                else if (timeout)          state_nx = IDLE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Counters, ownership and the registered output pixel path.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            in_cnt     <= '0;
            out_cnt    <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            m_valid    <= 1'b0;
            m_pixel    <= '0;
        end else begin
            m_valid <= out_fire;
            if (out_fire) begin
                m_pixel <= f_pixel_out;
                out_cnt <= out_cnt + CW'(1);
            end
            if (xfer) in_cnt <= in_cnt + CW'(1);
            if ((state == IDLE) && (|s_valid)) owner <= grant_owner;
            if (state == CLEAR) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end
            if ((state == DONE) || timeout) last_owner <= owner;
        end
    end

endmodule
